// File: rtl/uc_secuencial.sv
// Control unit for the single-cycle 8-bit microcontroller: decode, zero flag, HALT/resume, single-step.
// Optional retired-instruction counter on icount when UC_ICOUNT_EN is defined.
module uc_secuencial (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic        z,
   input  logic        go,
   input  logic        step_mode,
   input  logic        step_req,
   output logic        s_inc,
   output logic        s_inm,
   output logic        we3,
   output logic [2:0]  op,
   output logic        pc_en,
   output logic        halted,
   output logic        step_done,
   output logic        illegal,
   output logic [15:0] icount
);

   localparam int unsigned OPC_W = 6;
   localparam int unsigned CNT_W = 16;

   localparam logic [OPC_W-1:0] OPC_LI   = 6'b001000;
   localparam logic [OPC_W-1:0] OPC_J    = 6'b010000;
   localparam logic [OPC_W-1:0] OPC_JZ   = 6'b010001;
   localparam logic [OPC_W-1:0] OPC_JNZ  = 6'b010010;
   localparam logic [OPC_W-1:0] OPC_HALT = 6'b111111;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_RUN    = 3'd1,
      S_HALT   = 3'd2,
      S_RESUME = 3'd3,
      S_PAUSE  = 3'd4
   } state_t;

   state_t state;
   logic   zf;
   logic   is_alu_c;
   logic   is_halt_c;
   logic   exec_c;

   assign is_alu_c  = (opcode[5:3] == 3'b000);
   assign is_halt_c = (opcode == OPC_HALT);
   // An instruction executes in RUN, or in PAUSE when a step is requested.
   assign exec_c    = (state == S_RUN) || ((state == S_PAUSE) && step_req);

   // Datapath controls, combinational from state and opcode.
   always_comb begin
      pc_en   = 1'b0;
      we3     = 1'b0;
      s_inc   = 1'b1;
      s_inm   = 1'b0;
      op      = 3'b000;
      illegal = 1'b0;
      halted  = (state == S_HALT);
      if (state == S_RESUME) begin
         pc_en = 1'b1;
      end else if (exec_c && !is_halt_c) begin
         pc_en = 1'b1;
         if (is_alu_c) begin
            op  = opcode[2:0];
            we3 = 1'b1;
         end else begin
            case (opcode)
               OPC_LI: begin
                  we3   = 1'b1;
                  s_inm = 1'b1;
               end
               OPC_J:   s_inc = 1'b0;
               OPC_JZ:  s_inc = !zf;
               OPC_JNZ: s_inc = zf;
               default: illegal = 1'b1;
            endcase
         end
      end
   end

   // Sequencing, zero flag and step-done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_INIT;
         zf        <= 1'b0;
         step_done <= 1'b0;
      end else begin
         step_done <= 1'b0;
         if (exec_c && is_alu_c) begin
            zf <= z;
         end
         case (state)
            S_INIT: state <= S_RUN;
            S_RUN: begin
               if (is_halt_c)      state <= S_HALT;
               else if (step_mode) state <= S_PAUSE;
            end
            S_HALT: begin
               if (go) state <= S_RESUME;
            end
            S_RESUME: state <= step_mode ? S_PAUSE : S_RUN;
            S_PAUSE: begin
               if (step_req) begin
                  if (is_halt_c) begin
                     state <= S_HALT;
                  end else begin
                     step_done <= 1'b1;
                  end
               end else if (!step_mode) begin
                  state <= S_RUN;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

`ifdef UC_ICOUNT_EN
   logic [CNT_W-1:0] icount_q;

   // Counts every executed non-HALT instruction, illegal NOPs included.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         icount_q <= '0;
      end else if (exec_c && !is_halt_c) begin
         icount_q <= icount_q + CNT_W'(1);
      end
   end

   assign icount = icount_q;
`else
   assign icount = CNT_W'(0);
`endif

endmodule

// File: tb/tb_uc_secuencial.sv
// Self-checking bench for uc_secuencial: directed steps plus randomized opcodes against a flag-based model.
module tb_uc_secuencial;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        z = 1'b0, go = 1'b0, step_mode = 1'b0, step_req = 1'b0;
   logic        s_inc, s_inm, we3, pc_en, halted, step_done, illegal;
   logic [2:0]  op;
   logic [15:0] icount;

   int tests = 0;
   int fails = 0;

   // Behavioural model: mode flags, zero flag, pending step-done, retired count.
   bit          m_init, m_halted, m_resume, m_paused, m_zf, m_sd;
   logic [15:0] m_cnt;

   localparam logic [9:0] INACTIVE = 10'b0010000000;

   uc_secuencial dut (
      .clk(clk), .reset(reset), .opcode(opcode), .z(z), .go(go),
      .step_mode(step_mode), .step_req(step_req),
      .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .op(op), .pc_en(pc_en),
      .halted(halted), .step_done(step_done), .illegal(illegal), .icount(icount)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] cnt_exp(input logic [15:0] c);
`ifdef UC_ICOUNT_EN
      return c;
`else
      return 16'h0000 & c;
`endif
   endfunction

   task automatic check(input string tag, input logic [9:0] exp, input logic [15:0] exp_cnt);
      logic [9:0] got;
      got = {pc_en, we3, s_inc, s_inm, op, halted, step_done, illegal};
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s ctrl {pc_en,we3,s_inc,s_inm,op,halted,step_done,illegal}: observed %b expected %b",
                tag, got, exp);
      end
      tests++;
      assert (icount === exp_cnt) else begin
         fails++;
         $error("FAIL %s icount: observed %h expected %h", tag, icount, exp_cnt);
      end
   endtask

   // Reset asserted away from the clock edge; outputs must go inactive at once.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      repeat (3) begin
         #1;
         check(tag, INACTIVE, 16'h0000);
         @(posedge clk); #1;
      end
      reset = 1'b1;
      m_init = 1; m_halted = 0; m_resume = 0; m_paused = 0; m_zf = 0; m_sd = 0;
      m_cnt = 16'h0000;
   endtask

   // One clock cycle: drive inputs, check against the model, advance the model.
   task automatic cyc(input string tag, input logic [5:0] opc, input logic zz, input logic gg,
                      input logic sm, input logic sr);
      logic       pe, we, si, smo, il, ex, isalu, ishalt, sd_n;
      logic [2:0] o;
      opcode = opc; z = zz; go = gg; step_mode = sm; step_req = sr;
      #1;
      isalu  = (opc[5:3] == 3'b000);
      ishalt = (opc == 6'b111111);
      pe = 0; we = 0; si = 1; smo = 0; o = 3'b000; il = 0;
      ex = !m_init && !m_halted && !m_resume && (!m_paused || sr);
      if (m_resume) begin
         pe = 1;
      end else if (ex && !ishalt) begin
         pe = 1;
         if (isalu) begin
            o = opc[2:0]; we = 1;
         end else if (opc == 6'b001000) begin
            we = 1; smo = 1;
         end else if (opc == 6'b010000) si = 0;
         else if (opc == 6'b010001)     si = !m_zf;
         else if (opc == 6'b010010)     si = m_zf;
         else                           il = 1;
      end
      check(tag, {pe, we, si, smo, o, m_halted, m_sd, il}, cnt_exp(m_cnt));
      sd_n = 0;
      if (m_init) m_init = 0;
      else if (m_halted) begin
         if (gg) begin m_halted = 0; m_resume = 1; end
      end else if (m_resume) begin
         m_resume = 0; m_paused = sm;
      end else if (m_paused && !sr) begin
         if (!sm) m_paused = 0;
      end else begin
         if (isalu) m_zf = zz;
         if (ishalt) begin
            m_halted = 1; m_paused = 0;
         end else begin
            m_cnt = m_cnt + 16'h0001;
            if (m_paused) sd_n = 1;
            else          m_paused = sm;
         end
      end
      m_sd = sd_n;
      @(posedge clk); #1;
   endtask

   function automatic logic [5:0] rand_opc();
      case ($urandom_range(0, 9))
         0, 1, 2: return {3'b000, 3'($urandom)};
         3:       return 6'b001000;
         4:       return 6'b010000;
         5:       return 6'b010001;
         6:       return 6'b010010;
         7:       return 6'b111111;
         default: return 6'($urandom);
      endcase
   endfunction

   initial begin
      logic sm_r;
      do_reset("reset");
      cyc("init", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      // ALU sets zf, JZ follows it; then the z=0 case.
      cyc("alu_z1", 6'b000010, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("jz_taken", 6'b010001, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("alu_z0", 6'b000010, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("jz_not", 6'b010001, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("li", 6'b001000, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("jnz_after_li", 6'b010010, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc("j", 6'b010000, 1'b0, 1'b0, 1'b0, 1'b0);
      // HALT, idle, resume skip.
      cyc("halt", 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("halted_idle", 6'b111111, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("halted_go", 6'b111111, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc("resume", 6'b111111, 1'b0, 1'b0, 1'b0, 1'b0);
      // Single-step: enter PAUSE, step an illegal opcode, step a HALT.
      cyc("run_to_pause", 6'b000001, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("paused", 6'b100000, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("step_illegal", 6'b100000, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("step_done", 6'b000011, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("step_held_a", 6'b000011, 1'b1, 1'b0, 1'b0, 1'b1);
      cyc("step_held_b", 6'b010001, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc("step_halt", 6'b111111, 1'b0, 1'b0, 1'b1, 1'b1);
      cyc("halt_after_step", 6'b111111, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc("resume_to_pause", 6'b000000, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc("pause_exit", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("back_in_run", 6'b000101, 1'b0, 1'b0, 1'b0, 1'b0);

      // Randomized operation.
      sm_r = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 19) == 0) sm_r = !sm_r;
         cyc("rand", rand_opc(), 1'($urandom), ($urandom_range(0, 3) == 0),
             sm_r, ($urandom_range(0, 2) == 0));
      end

      // Asynchronous reset in the middle of operation.
      cyc("pre_reset", 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0);
      do_reset("mid_reset");
      cyc("init2", 6'b000111, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc("zf_cleared", 6'b010010, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef UC_ICOUNT_EN
      do_reset("wrap_reset");
      cyc("wrap_init", 6'b000000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 65537; i++) cyc("wrap_alu", 6'b000001, 1'b0, 1'b0, 1'b0, 1'b0);
      tests++;
      assert (icount === 16'h0001) else begin
         fails++;
         $error("FAIL icount_wrap: observed %h expected 0001", icount);
      end
      do_reset("wrap_mid_reset");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uc_secuencial.md
Name: uc_secuencial

Overview:
- Control unit for the single-cycle 8-bit microcontroller datapath (PC, program memory, register file, ALU).
- Decodes the 6-bit opcode and the ALU zero output each cycle and drives the datapath control signals `s_inc`, `s_inm`, `we3`, `op`, and a new PC-enable, `pc_en`.
- Adds sequencing the datapath lacks: a registered zero flag, a HALT state with resume, and single-step debug with a req/done handshake.
- The datapath PC register is gated by `pc_en`, so the PC holds whenever `pc_en`=0.

Parameters:
- None.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction bits [5:0] from the datapath.
- z  in  1  combinational ALU zero output.
- go  in  1  resume request; sampled while in HALT.
- step_mode  in  1  1 = single-step debug mode.
- step_req  in  1  execute one instruction; sampled while in PAUSE.
- s_inc  out  1  1 = PC+1; 0 = jump target from instruction [15:6].
- s_inm  out  1  1 = immediate [11:4] to the register file; 0 = ALU result.
- we3  out  1  register file write enable.
- op  out  3  ALU operation.
- pc_en  out  1  PC register load enable.
- halted  out  1  high while in HALT.
- step_done  out  1  one-cycle pulse after a stepped instruction executes.
- illegal  out  1  one-cycle pulse on an undefined opcode.
- icount  out  16  retired-instruction count (see Optional Feature).

Behaviour:
- Decode (applies only when an instruction executes):
  - `opcode[5:3]`=000 → ALU op: `op`=`opcode[2:0]`, `we3`=1, `s_inm`=0, `s_inc`=1; `zf` loads `z` at the clock edge.
  - 001000 → LI: `we3`=1, `s_inm`=1, `s_inc`=1.
  - 010000 → J: `s_inc`=0.
  - 010001 → JZ: `s_inc`=!`zf`.
  - 010010 → JNZ: `s_inc`=`zf`.
  - 111111 → HALT.
  - Any other opcode → treated as NOP (`we3`=0, `s_inc`=1), `illegal` pulses for that cycle.
- Zero flag:
  - `zf` is a register, reset 0, updated only by ALU instructions.
  - A jump immediately following an ALU instruction sees that instruction's result.
- Inactive output set: `pc_en`=0, `we3`=0, `s_inc`=1, `s_inm`=0, `op`=000.
- Outputs are combinational from state and opcode. During reset (state INIT) all outputs are the inactive set, `halted`=0, `step_done`=0, `illegal`=0.
- States:
  - INIT: inactive outputs. Next state is RUN unconditionally; the one cycle lets the PC-0 instruction settle.
  - RUN: executes one instruction per cycle with `pc_en`=1.
    - HALT opcode: `pc_en`=0, `we3`=0, next state HALT. The PC stays on the HALT word.
    - Otherwise, if `step_mode`=1, next state PAUSE after executing. If `step_mode`=0, remain in RUN.
  - HALT: inactive outputs, `halted`=1. On `go`=1: next state RESUME.
  - RESUME: `pc_en`=1, `s_inc`=1, `we3`=0 for one cycle (skips the HALT word). Next state RUN, or PAUSE if `step_mode`=1.
  - PAUSE: inactive outputs; the instruction at the PC is not executed. On `step_req`=1:
    - That cycle executes the current instruction exactly as in RUN.
    - `step_done` pulses on the following cycle.
    - Stay in PAUSE. If the instruction was HALT, go to HALT instead, with no `step_done`.
    - If `step_mode`=0 and `step_req`=0, next state RUN.
- Simultaneous events:
  - `step_req`=1 takes priority over `step_mode` falling.
  - `go` is ignored outside HALT; `step_req` is ignored outside PAUSE.
  - `step_req` held high executes one instruction per cycle.
- Reset mid-operation, in any state: immediate return to INIT, `zf`=0, counter cleared, all pulses cleared.
- `illegal` and `step_done` are never asserted while `reset`=0.

Optional Feature:
- Macro: UC_ICOUNT_EN.
- Defined: 16-bit counter, reset 0, increments on every cycle in which a non-HALT instruction executes (RUN, or PAUSE with `step_req`). Illegal-opcode NOPs count; RESUME skips do not. Wraps FFFF→0000. Driven on `icount`.
- Undefined: `icount` is tied to 0 and no counter flops are synthesized.

Test Plan:
- Reset low 3 cycles, release → outputs inactive for exactly 1 cycle (INIT), then `pc_en`=1; `zf`=0.
- ALU opcode 000010 with `z`=1, then JZ opcode 010001 → `op`=010, `we3`=1 on the first cycle; `s_inc`=0 on the JZ cycle. Repeat with `z`=0 → `s_inc`=1.
- LI opcode 001000 → `we3`=1, `s_inm`=1, `s_inc`=1; `zf` unchanged from the previous value.
- HALT opcode 111111 → `pc_en`=0 that cycle, `halted`=1 from the next cycle. `go` pulse → 1 cycle with `pc_en`=1, `we3`=0, then RUN.
- `step_mode`=1 in RUN → PAUSE after 1 instruction. `step_req` pulse → exactly one instruction with `pc_en`=1, `step_done` the next cycle. Opcode 100000 → `illegal` pulses, `we3`=0.
- With UC_ICOUNT_EN, run 65537 ALU instructions → `icount`=0001 (wrapped). Assert `reset`=0 mid-run → `icount`=0 and state INIT immediately (asynchronously).
